// File: rtl/core_wbu_pkg.sv
// Shared types and constants for the write-back unit.
package core_wbu_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int GPR_NUM   = 1 << GPR_IDX_W;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } wbu_state_e;

  // Write-data select flags as delivered by the execute stage.
  typedef struct packed {
    logic imme;
    logic pc;
    logic pc_seq;
    logic csr;
    logic alu;
  } wb_sel_t;

  function automatic logic sel_any(input wb_sel_t s);
    return |s;
  endfunction

endpackage

// File: rtl/core_wbu_gpr.sv
// 32 x XLEN register file: one write port, two read ports with write bypass, x0 tied to zero.
module core_wbu_gpr
  import core_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                we,
  input  logic [GPR_IDX_W-1:0]                waddr,
  input  logic [XLEN-1:0]                     wdata,
  input  logic [1:0][GPR_IDX_W-1:0]           raddr,
  output logic [1:0][XLEN-1:0]                rdata
);

  logic [XLEN-1:0] rf [GPR_NUM];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < GPR_NUM; i++) rf[i] <= '0;
    end else if (we && (waddr != '0)) begin
      rf[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      if (raddr[p] == '0)
        rdata[p] = XLEN'(ZERO_WORD);
      else if (we && (waddr == raddr[p]))
        rdata[p] = wdata;
      else
        rdata[p] = rf[raddr[p]];
    end
  end

endmodule

// File: rtl/core_wbu_top.sv
// Write-back stage: single-entry buffer, write-data select, GPR write/read, scoreboard, minstret.
module core_wbu_top
  import core_wbu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wbu_rx_valid,
  output logic                 wbu_rx_ready,
  input  logic [XLEN-1:0]      wbu_rx_exu_res,
  input  logic [XLEN-1:0]      wbu_rx_pc_seq,
  input  logic [XLEN-1:0]      wbu_rx_imme,
  input  logic                 wbu_rx_imme_valid,
  input  logic                 wbu_rx_pc_valid,
  input  logic                 wbu_rx_pc_seq_valid,
  input  logic                 wbu_rx_csr_valid,
  input  logic                 wbu_rx_alu_valid,
  input  logic [GPR_IDX_W-1:0] wbu_rx_rd_idx,
  input  logic                 wbu_halt,
  input  logic [GPR_IDX_W-1:0] gpr_raddr1,
  input  logic [GPR_IDX_W-1:0] gpr_raddr2,
  output logic [XLEN-1:0]      gpr_rdata1,
  output logic [XLEN-1:0]      gpr_rdata2,
  input  logic                 sb_set_valid,
  input  logic [GPR_IDX_W-1:0] sb_set_idx,
  output logic [GPR_NUM-1:0]   sb_busy,
  output logic                 wbu_commit,
  output logic [CNT_W-1:0]     wbu_minstret
);

  wbu_state_e           state;
  logic [XLEN-1:0]      buf_exu_res, buf_pc_seq, buf_imme;
  wb_sel_t              buf_sel, rx_sel;
  logic [GPR_IDX_W-1:0] buf_rd;

  logic                 commit, rx_ena;
  logic                 gpr_we;
  logic [XLEN-1:0]      wr_data;
  logic [GPR_NUM-1:0]   sb_nxt;
  logic [1:0][XLEN-1:0] rdata;

  assign rx_sel = '{imme:   wbu_rx_imme_valid,
                    pc:     wbu_rx_pc_valid,
                    pc_seq: wbu_rx_pc_seq_valid,
                    csr:    wbu_rx_csr_valid,
                    alu:    wbu_rx_alu_valid};

  assign commit       = (state == S_FULL) && !wbu_halt;
  assign wbu_rx_ready = (state == S_IDLE) || commit;
  assign rx_ena       = wbu_rx_valid && wbu_rx_ready;
  assign wbu_commit   = commit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      buf_exu_res <= '0;
      buf_pc_seq  <= '0;
      buf_imme    <= '0;
      buf_sel     <= '0;
      buf_rd      <= '0;
    end else begin
      case (state)
        S_IDLE: if (rx_ena) state <= S_FULL;
        S_FULL: if (commit && !rx_ena) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (rx_ena) begin
        buf_exu_res <= wbu_rx_exu_res;
        buf_pc_seq  <= wbu_rx_pc_seq;
        buf_imme    <= wbu_rx_imme;
        buf_sel     <= rx_sel;
        buf_rd      <= wbu_rx_rd_idx;
      end
    end
  end

  // pc and csr results both travel on exu_res, so they share the fallthrough.
  always_comb begin
    wr_data = buf_exu_res;
    if (buf_sel.alu)         wr_data = buf_exu_res;
    else if (buf_sel.imme)   wr_data = buf_imme;
    else if (buf_sel.pc_seq) wr_data = buf_pc_seq;
  end

  assign gpr_we = commit && sel_any(buf_sel) && (buf_rd != '0);

  core_wbu_gpr #(.XLEN(XLEN)) u_gpr (
    .clk   (clk),
    .rstn  (rstn),
    .we    (gpr_we),
    .waddr (buf_rd),
    .wdata (wr_data),
    .raddr ({gpr_raddr2, gpr_raddr1}),
    .rdata (rdata)
  );

  assign gpr_rdata1 = rdata[0];
  assign gpr_rdata2 = rdata[1];

  // Clear is applied first so a same-cycle set on the same index wins.
  always_comb begin
    sb_nxt = sb_busy;
    if (commit)       sb_nxt[buf_rd]     = 1'b0;
    if (sb_set_valid) sb_nxt[sb_set_idx] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_busy      <= '0;
      wbu_minstret <= '0;
    end else begin
      sb_busy <= sb_nxt;
      if (commit) wbu_minstret <= wbu_minstret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_wbu_top.sv
// Directed table-driven bench for core_wbu_top plus a mid-operation reset sequence.
module tb_core_wbu_top;

  localparam logic [4:0] F_NONE  = 5'b00000;  // {imme, pc, pc_seq, csr, alu}
  localparam logic [4:0] F_ALU   = 5'b00001;
  localparam logic [4:0] F_CSR   = 5'b00010;
  localparam logic [4:0] F_PCSEQ = 5'b00100;
  localparam logic [4:0] F_PC    = 5'b01000;
  localparam logic [4:0] F_IMM   = 5'b10000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wbu_rx_valid = 1'b0;
  logic        wbu_rx_ready;
  logic [31:0] wbu_rx_exu_res = '0, wbu_rx_pc_seq = '0, wbu_rx_imme = '0;
  logic        wbu_rx_imme_valid = 1'b0, wbu_rx_pc_valid = 1'b0, wbu_rx_pc_seq_valid = 1'b0;
  logic        wbu_rx_csr_valid = 1'b0, wbu_rx_alu_valid = 1'b0;
  logic [4:0]  wbu_rx_rd_idx = '0;
  logic        wbu_halt = 1'b0;
  logic [4:0]  gpr_raddr1 = '0, gpr_raddr2 = '0;
  logic [31:0] gpr_rdata1, gpr_rdata2;
  logic        sb_set_valid = 1'b0;
  logic [4:0]  sb_set_idx = '0;
  logic [31:0] sb_busy;
  logic        wbu_commit;
  logic [63:0] wbu_minstret;

  int checks = 0;
  int failures = 0;

  core_wbu_top dut (
    .clk(clk), .rstn(rstn),
    .wbu_rx_valid(wbu_rx_valid), .wbu_rx_ready(wbu_rx_ready),
    .wbu_rx_exu_res(wbu_rx_exu_res), .wbu_rx_pc_seq(wbu_rx_pc_seq), .wbu_rx_imme(wbu_rx_imme),
    .wbu_rx_imme_valid(wbu_rx_imme_valid), .wbu_rx_pc_valid(wbu_rx_pc_valid),
    .wbu_rx_pc_seq_valid(wbu_rx_pc_seq_valid), .wbu_rx_csr_valid(wbu_rx_csr_valid),
    .wbu_rx_alu_valid(wbu_rx_alu_valid), .wbu_rx_rd_idx(wbu_rx_rd_idx),
    .wbu_halt(wbu_halt),
    .gpr_raddr1(gpr_raddr1), .gpr_raddr2(gpr_raddr2),
    .gpr_rdata1(gpr_rdata1), .gpr_rdata2(gpr_rdata2),
    .sb_set_valid(sb_set_valid), .sb_set_idx(sb_set_idx), .sb_busy(sb_busy),
    .wbu_commit(wbu_commit), .wbu_minstret(wbu_minstret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] exu;
    logic [31:0] pcs;
    logic [31:0] imm;
    logic [4:0]  flg;
    logic [4:0]  rd;
    logic        halt;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        sv;
    logic [4:0]  si;
    logic        e_rdy;
    logic        e_cm;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_sb;
    logic [63:0] e_mi;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    wbu_rx_valid        = v.vld;
    wbu_rx_exu_res      = v.exu;
    wbu_rx_pc_seq       = v.pcs;
    wbu_rx_imme         = v.imm;
    {wbu_rx_imme_valid, wbu_rx_pc_valid, wbu_rx_pc_seq_valid,
     wbu_rx_csr_valid, wbu_rx_alu_valid} = v.flg;
    wbu_rx_rd_idx       = v.rd;
    wbu_halt            = v.halt;
    gpr_raddr1          = v.ra1;
    gpr_raddr2          = v.ra2;
    sb_set_valid        = v.sv;
    sb_set_idx          = v.si;
  endtask

  initial begin
    // vld exu pcs imm flg rd halt ra1 ra2 sv si | rdy cm rd1 rd2 sb mi
    // ALU write x5 with bypass in the commit cycle
    vq.push_back('{1, 32'h1234, 0, 0, F_ALU, 5, 0, 5, 0, 1, 5,   1, 0, 32'h0,    32'h0, 32'h0,  64'd0});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 5, 0, 0, 0,         1, 1, 32'h1234, 32'h0, 32'h20, 64'd0});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 5, 0, 0, 0,         1, 0, 32'h1234, 32'h0, 32'h0,  64'd1});
    // x0 write dropped, x0 scoreboard set ignored
    vq.push_back('{1, 0, 0, 32'hDEADB000, F_IMM, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0, 64'd1});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 0, 0, 0, 0,         1, 1, 32'h0,    32'h0,    32'h0, 64'd1});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 0, 5, 0, 0,         1, 0, 32'h0,    32'h1234, 32'h0, 64'd2});
    // back-to-back LUI x1, JAL x2, AUIPC x3, branch (no flags, rd=4)
    vq.push_back('{1, 0, 0, 32'h12345000, F_IMM, 1, 0, 1, 2, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 64'd2});
    vq.push_back('{1, 32'h100, 32'h104, 0, F_PCSEQ, 2, 0, 1, 2, 0, 0, 1, 1, 32'h12345000, 32'h0, 32'h0, 64'd2});
    vq.push_back('{1, 32'h80001000, 0, 0, F_PC, 3, 0, 2, 3, 0, 0, 1, 1, 32'h104, 32'h0, 32'h0, 64'd3});
    vq.push_back('{1, 32'hBAD, 0, 0, F_NONE, 4, 0, 3, 1, 0, 0,  1, 1, 32'h80001000, 32'h12345000, 32'h0, 64'd4});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 4, 2, 0, 0,         1, 1, 32'h0, 32'h104,      32'h0, 64'd5});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 4, 3, 0, 0,         1, 0, 32'h0, 32'h80001000, 32'h0, 64'd6});
    // halt for three cycles while full; competing rx must not be taken
    vq.push_back('{1, 32'hCAFE0001, 0, 0, F_CSR, 6, 0, 6, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 64'd6});
    vq.push_back('{1, 32'h11111111, 0, 0, F_ALU, 6, 1, 6, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 64'd6});
    vq.push_back('{1, 32'h11111111, 0, 0, F_ALU, 6, 1, 6, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 64'd6});
    vq.push_back('{1, 32'h11111111, 0, 0, F_ALU, 6, 1, 6, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 64'd6});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 6, 0, 0, 0,         1, 1, 32'hCAFE0001, 32'h0, 32'h0, 64'd6});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 6, 0, 0, 0,         1, 0, 32'hCAFE0001, 32'h0, 32'h0, 64'd7});
    // scoreboard: set x7, commit x7 with a same-cycle set (set wins), then plain commit clears
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 7, 0, 1, 7,         1, 0, 32'h0,  32'h0, 32'h0,  64'd7});
    vq.push_back('{1, 32'h77, 0, 0, F_ALU, 7, 0, 7, 0, 0, 0,     1, 0, 32'h0,  32'h0, 32'h80, 64'd7});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 7, 0, 1, 7,         1, 1, 32'h77, 32'h0, 32'h80, 64'd7});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 7, 0, 0, 0,         1, 0, 32'h77, 32'h0, 32'h80, 64'd8});
    vq.push_back('{1, 32'h78, 0, 0, F_ALU, 7, 0, 7, 0, 0, 0,     1, 0, 32'h77, 32'h0, 32'h80, 64'd8});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 7, 0, 0, 0,         1, 1, 32'h78, 32'h0, 32'h80, 64'd8});
    vq.push_back('{0, 0, 0, 0, F_NONE, 0, 0, 7, 0, 0, 0,         1, 0, 32'h78, 32'h0, 32'h0,  64'd9});

    // reset state
    #12;
    chk("rst ready", 64'(wbu_rx_ready), 64'd1);
    chk("rst commit", 64'(wbu_commit), 64'd0);
    chk("rst sb_busy", 64'(sb_busy), 64'd0);
    chk("rst minstret", wbu_minstret, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      @(negedge clk);
      chk($sformatf("v%0d ready", i),    64'(wbu_rx_ready), 64'(vq[i].e_rdy));
      chk($sformatf("v%0d commit", i),   64'(wbu_commit),   64'(vq[i].e_cm));
      chk($sformatf("v%0d rdata1", i),   64'(gpr_rdata1),   64'(vq[i].e_rd1));
      chk($sformatf("v%0d rdata2", i),   64'(gpr_rdata2),   64'(vq[i].e_rd2));
      chk($sformatf("v%0d sb_busy", i),  64'(sb_busy),      64'(vq[i].e_sb));
      chk($sformatf("v%0d minstret", i), wbu_minstret,      vq[i].e_mi);
      @(posedge clk); #1;
    end

    // reset while full with x9 = 0xFFFF_FFFF pending
    apply('{1, 32'hFFFFFFFF, 0, 0, F_ALU, 9, 0, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    wbu_rx_valid = 1'b0;
    @(negedge clk);
    chk("prerst commit", 64'(wbu_commit), 64'd1);
    chk("prerst bypass", 64'(gpr_rdata1), 64'hFFFFFFFF);
    chk("prerst minstret", wbu_minstret, 64'd9);
    #1 rstn = 1'b0;
    #1;
    chk("inrst commit", 64'(wbu_commit), 64'd0);
    chk("inrst ready", 64'(wbu_rx_ready), 64'd1);
    chk("inrst minstret", wbu_minstret, 64'd0);
    chk("inrst x5", 64'(gpr_rdata2), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst x9", 64'(gpr_rdata1), 64'd0);
    chk("postrst ready", 64'(wbu_rx_ready), 64'd1);
    chk("postrst commit", 64'(wbu_commit), 64'd0);
    chk("postrst minstret", wbu_minstret, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
